// File: rtl/csla_seq_ctrl.sv
// Sequential W-bit adder: one 4-bit carry-select slice reused over NIBBLES cycles.
// Optional subtraction (A - B) is compiled in with `define CSLA_SEQ_SUB_EN.

module csla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [2:0] w_lo;
    logic [2:0] w_hi0;
    logic [2:0] w_hi1;

    // Upper pair precomputed for both carries, selected by the lower pair's carry.
    assign w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    assign w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign w_hi1 = w_hi0 + 3'd1;
    assign sum   = {(w_lo[2] ? w_hi1[1:0] : w_hi0[1:0]), w_lo[1:0]};
    assign cout  = w_lo[2] ? w_hi1[2] : w_hi0[2];
endmodule

module csla_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b, r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_carry, r_cout, r_ovf;
    logic            w_accept, w_last, w_cin_first;
    logic [W-1:0]    w_b_eff;
    logic [IW+1:0]   w_sh;
    logic [3:0]      w_s;
    logic            w_co;

`ifdef CSLA_SEQ_SUB_EN
    logic r_sub;
    assign w_b_eff     = r_sub ? ~r_b : r_b;
    assign w_cin_first = op_sub ? 1'b1 : cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = op_sub;
    assign w_b_eff      = r_b;
    assign w_cin_first  = cin;
`endif

    assign w_last = (r_idx == IW'(NIBBLES - 1));
    assign w_sh   = {r_idx, 2'b00};

    csla_4bit u_slice (
        .a    (r_a[w_sh +: 4]),
        .b    (w_b_eff[w_sh +: 4]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN:  if (w_last) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The captured carry-in seeds the carry register, so slice 0 and later
    // slices share one carry path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef CSLA_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= w_cin_first;
`ifdef CSLA_SEQ_SUB_EN
            r_sub   <= op_sub;
`endif
        end else if (r_state == RUN) begin
            r_sum[w_sh +: 4] <= w_s;
            r_carry          <= w_co;
            r_idx            <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= (r_a[W-1] == w_b_eff[W-1]) && (w_s[3] != r_a[W-1]);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule
